// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and default widths for the PC, fetch and decode stages.
package instr_fetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // True while a memory read is outstanding.
    function automatic logic waits_mem(fetch_state_t s);
        return (s == REQ) || (s == DROP);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for an outstanding fetch; flags expiry on the LIMIT-th waiting cycle.
module fetch_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sample, memory read, IR hold with decode handshake.
// Optional fetch timeout with sticky error is enabled by FETCH_TIMEOUT_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic               fetch_en,
    input  logic               flush,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               pc_advance,
    output logic               fetch_err
);

    fetch_state_t state_q, state_d;

    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               pc_adv_q, pc_adv_d;
    logic               ctr_clr;
    logic               err_set;
    logic               tmo;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        pc_adv_d   = 1'b0;
        ctr_clr    = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_en && !flush) begin
                    state_d    = REQ;
                    mem_addr_d = pc_addr;
                    ctr_clr    = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = HOLD;
                        ir_data_d = mem_rdata;
                        ir_pc_d   = mem_addr_q;
                        pc_adv_d  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DROP;
                    ctr_clr = 1'b1;
                end else if (tmo) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end
            end
            HOLD: begin
                // Flush wins over a simultaneous decode accept.
                if (flush || ir_ready) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            pc_adv_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            pc_adv_q   <= pc_adv_d;
        end
    end

    assign mem_req    = waits_mem(state_q);
    assign mem_addr   = mem_addr_q;
    assign ir_valid   = (state_q == HOLD);
    assign ir_data    = ir_data_q;
    assign ir_pc      = ir_pc_q;
    assign pc_advance = pc_adv_q;

`ifdef FETCH_TIMEOUT_EN
    logic err_q;

    fetch_timeout_ctr #(
        .LIMIT(TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (ctr_clr),
        .en_i    (mem_req),
        .expire_o(tmo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_tmo_cfg;

    assign tmo            = 1'b0;
    assign fetch_err      = 1'b0;
    assign unused_tmo_cfg = ^{err_set, ctr_clr, TIMEOUT_CYC[0]};
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for the instr_fetch stage.
module tb_instr_fetch;

`ifdef FETCH_TIMEOUT_EN
    localparam int TCYC = 4;
`else
    localparam int TCYC = 15;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_addr;
    logic        fetch_en;
    logic        flush;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [7:0]  ir_pc;
    logic        pc_advance;
    logic        fetch_err;

    int cmp  = 0;
    int errs = 0;
    int adv_total = 0;
    int adv_base;

    instr_fetch #(
        .ADDR_W     (8),
        .INSTR_W    (16),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_addr   (pc_addr),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_data   (ir_data),
        .ir_pc     (ir_pc),
        .pc_advance(pc_advance),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pc_advance === 1'b1) adv_total++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pc_addr   = 8'h00;
        fetch_en  = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        ir_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        adv_base = adv_total;
    endtask

    task automatic test_reset();
        do_reset();
        reset    = 1'b1;
        fetch_en = 1'b1;
        pc_addr  = 8'h33;
        step();
        cmp++;
        if ({mem_req, mem_addr, ir_valid, ir_data, ir_pc, pc_advance, fetch_err}
            !== 36'h0) begin
            $display("FAIL reset_outs: req=%b addr=%h v=%b d=%h pc=%h adv=%b err=%b want all 0",
                     mem_req, mem_addr, ir_valid, ir_data, ir_pc, pc_advance, fetch_err);
            errs++;
        end
        reset    = 1'b0;
        fetch_en = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h10;
        ir_ready = 1'b1;
        step();
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h10 || ir_valid !== 1'b0) begin
            $display("FAIL basic_req: req=%b addr=%h v=%b want 1/10/0", mem_req, mem_addr, ir_valid);
            errs++;
        end
        pc_addr = 8'h99;
        step();
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin
            $display("FAIL basic_addr_hold: req=%b addr=%h want 1/10", mem_req, mem_addr);
            errs++;
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hA55A;
        step();
        mem_ack  = 1'b0;
        fetch_en = 1'b0;
        cmp++;
        if ({ir_valid, ir_data, ir_pc, pc_advance, mem_req} !== {1'b1, 16'hA55A, 8'h10, 1'b1, 1'b0}) begin
            $display("FAIL basic_hold: v=%b d=%h pc=%h adv=%b req=%b want 1/a55a/10/1/0",
                     ir_valid, ir_data, ir_pc, pc_advance, mem_req);
            errs++;
        end
        step();
        step();
        cmp++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b0 || adv_total - adv_base != 1) begin
            $display("FAIL basic_done: v=%b req=%b pulses=%0d want 0/0/1",
                     ir_valid, mem_req, adv_total - adv_base);
            errs++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h20;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        pc_addr = 8'h21;
        for (int i = 0; i < 5; i++) begin
            cmp++;
            if ({ir_valid, ir_data, ir_pc, mem_req, pc_advance}
                !== {1'b1, 16'h1234, 8'h20, 1'b0, (i == 0)}) begin
                $display("FAIL bp_hold_%0d: v=%b d=%h pc=%h req=%b adv=%b want 1/1234/20/0/%0d",
                         i, ir_valid, ir_data, ir_pc, mem_req, pc_advance, (i == 0));
                errs++;
            end
            step();
        end
        ir_ready = 1'b1;
        step();
        cmp++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL bp_release: v=%b req=%b want 0/0", ir_valid, mem_req);
            errs++;
        end
        step();
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h21) begin
            $display("FAIL bp_next_req: req=%b addr=%h want 1/21", mem_req, mem_addr);
            errs++;
        end
    endtask

    task automatic test_flush_req();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h30;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h30 || ir_valid !== 1'b0) begin
            $display("FAIL drop_enter: req=%b addr=%h v=%b want 1/30/0", mem_req, mem_addr, ir_valid);
            errs++;
        end
        flush = 1'b1;
        step();
        flush    = 1'b0;
        fetch_en = 1'b0;
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h30) begin
            $display("FAIL drop_reflush: req=%b addr=%h want 1/30", mem_req, mem_addr);
            errs++;
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        cmp++;
        if ({mem_req, ir_valid, pc_advance} !== 3'b000 || adv_total - adv_base != 0) begin
            $display("FAIL drop_ack: req=%b v=%b adv=%b pulses=%0d want 0/0/0/0",
                     mem_req, ir_valid, pc_advance, adv_total - adv_base);
            errs++;
        end
        step();
        cmp++;
        if ({mem_req, ir_valid} !== 2'b00 || adv_total - adv_base != 0) begin
            $display("FAIL drop_idle: req=%b v=%b pulses=%0d want 0/0/0",
                     mem_req, ir_valid, adv_total - adv_base);
            errs++;
        end
    endtask

    task automatic test_flush_hold();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h38;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        step();
        mem_ack  = 1'b0;
        flush    = 1'b1;
        ir_ready = 1'b1;
        pc_addr  = 8'h40;
        step();
        flush    = 1'b0;
        ir_ready = 1'b0;
        cmp++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL fh_drop: v=%b req=%b want 0/0", ir_valid, mem_req);
            errs++;
        end
        step();
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin
            $display("FAIL fh_refetch: req=%b addr=%h want 1/40", mem_req, mem_addr);
            errs++;
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        fetch_en  = 1'b0;
        step();
        mem_ack = 1'b0;
        cmp++;
        if ({ir_valid, ir_data, ir_pc} !== {1'b1, 16'h7777, 8'h40}) begin
            $display("FAIL fh_capture: v=%b d=%h pc=%h want 1/7777/40", ir_valid, ir_data, ir_pc);
            errs++;
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h50;
        step();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        step();
        reset    = 1'b0;
        mem_ack  = 1'b0;
        fetch_en = 1'b0;
        cmp++;
        if ({mem_req, mem_addr, ir_valid, ir_data, ir_pc, pc_advance} !== 35'h0) begin
            $display("FAIL rst_mid: req=%b addr=%h v=%b d=%h pc=%h adv=%b want all 0",
                     mem_req, mem_addr, ir_valid, ir_data, ir_pc, pc_advance);
            errs++;
        end
        step();
        cmp++;
        if ({mem_req, ir_valid, pc_advance} !== 3'b000) begin
            $display("FAIL rst_mid_idle: req=%b v=%b adv=%b want 0/0/0", mem_req, ir_valid, pc_advance);
            errs++;
        end
    endtask

    task automatic test_ack_flush();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h60;
        step();
        fetch_en  = 1'b0;
        mem_ack   = 1'b1;
        flush     = 1'b1;
        mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        flush   = 1'b0;
        cmp++;
        if ({mem_req, ir_valid, pc_advance} !== 3'b000 || ir_data !== 16'h0000) begin
            $display("FAIL ackflush: req=%b v=%b adv=%b d=%h want 0/0/0/0000",
                     mem_req, ir_valid, pc_advance, ir_data);
            errs++;
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h2222;
        step();
        mem_ack  = 1'b0;
        fetch_en = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        fetch_en = 1'b0;
        cmp++;
        if ({mem_req, ir_valid} !== 2'b00 || ir_data !== 16'h0000
            || adv_total - adv_base != 0) begin
            $display("FAIL idle_ignore: req=%b v=%b d=%h pulses=%0d want 0/0/0000/0",
                     mem_req, ir_valid, ir_data, adv_total - adv_base);
            errs++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] last_pc;
        last_pc = 8'h00;
        do_reset();
        fetch_en  = 1'b1;
        ir_ready  = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hC3C3;
        pc_addr   = 8'h70;
        for (int i = 0; i < 9; i++) begin
            step();
            if (ir_valid === 1'b1) last_pc = ir_pc;
            if (pc_advance === 1'b1) pc_addr = pc_addr + 8'h01;
        end
        mem_ack  = 1'b0;
        fetch_en = 1'b0;
        cmp++;
        if (adv_total - adv_base != 3 || last_pc !== 8'h72) begin
            $display("FAIL b2b: pulses=%0d last_pc=%h want 3/72", adv_total - adv_base, last_pc);
            errs++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        fetch_en = 1'b1;
        pc_addr  = 8'h80;
        step();
        fetch_en = 1'b0;
        step();
        step();
        step();
        cmp++;
        if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin
            $display("FAIL tmo_wait: req=%b err=%b want 1/0", mem_req, fetch_err);
            errs++;
        end
`ifdef FETCH_TIMEOUT_EN
        step();
        cmp++;
        if ({mem_req, fetch_err, ir_valid, pc_advance} !== 4'b0100) begin
            $display("FAIL tmo_expire: req=%b err=%b v=%b adv=%b want 0/1/0/0",
                     mem_req, fetch_err, ir_valid, pc_advance);
            errs++;
        end
        fetch_en = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'h4242;
        step();
        mem_ack  = 1'b0;
        fetch_en = 1'b0;
        cmp++;
        if (fetch_err !== 1'b1 || ir_valid !== 1'b1) begin
            $display("FAIL tmo_sticky: err=%b v=%b want 1/1", fetch_err, ir_valid);
            errs++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmp++;
        if (fetch_err !== 1'b0) begin
            $display("FAIL tmo_clear: err=%b want 0", fetch_err);
            errs++;
        end
`else
        repeat (20) step();
        cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h80 || fetch_err !== 1'b0) begin
            $display("FAIL no_tmo: req=%b addr=%h err=%b want 1/80/0", mem_req, mem_addr, fetch_err);
            errs++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_req();
        test_flush_hold();
        test_reset_mid_req();
        test_ack_flush();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
